// File: rtl/wb_stage_pkg.sv
// Shared widths, exception codes and bus layouts for the writeback stage.
package wb_stage_pkg;

    localparam int unsigned MS2WS_LEN    = 199;
    localparam int unsigned WB2CSR_LEN   = 81;
    localparam int unsigned CSR_CTRL_LEN = 80;
    localparam int unsigned WS_FWD_LEN   = 38;

    // Interrupts are reported with a zero exception code and subcode
    localparam logic [5:0] ECODE_INT     = 6'h00;
    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    // MEM -> WB instruction fields, MSB first
    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic [13:0] csr_num;
        logic        csr_re;
        logic        csr_we;
        logic [31:0] csr_wvalue;
        logic [31:0] csr_wmask;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
        logic        ertn;
    } ms2ws_bus_t;

    // WB -> CSR exception/return report, MSB first
    typedef struct packed {
        logic        ertn_flush;
        logic        wb_ex;
        logic [5:0]  wb_ecode;
        logic [8:0]  wb_esubcode;
        logic [31:0] wb_pc;
        logic [31:0] wb_vaddr;
    } ws2csr_bus_t;

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per cycle, raises exceptions,
// interrupts and ertn redirects, and drives RF/CSR writes and ID bypass.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ms_to_ws_valid,
    input  logic [MS2WS_LEN-1:0]    ms_to_ws_bus,
    output logic                    ws_allow_in,
    output logic [CSR_CTRL_LEN-1:0] csr_ctrl,
    output logic                    csr_valid,
    output logic [WB2CSR_LEN-1:0]   ws_to_csr_bus,
    input  logic [31:0]             csr_rvalue,
    input  logic [31:0]             ex_entry,
    input  logic [31:0]             era_pc,
    input  logic                    has_int,
    output logic                    ws_flush,
    output logic [31:0]             flush_target,
    output logic [WS_FWD_LEN-1:0]   ws_fwd,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic [31:0]             debug_wb_pc,
    output logic [3:0]              debug_wb_rf_we,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [31:0]             debug_wb_rf_wdata
);

    ms2ws_bus_t  ws_bus_q, ws_bus_d;
    logic        ws_valid_q, ws_valid_d;
    ms2ws_bus_t  ms_bus;
    ws2csr_bus_t csr_bus;
    logic        ws_ready_go;
    logic        take_int;
    logic        wb_ex;
    logic        ertn_flush;

    assign ms_bus      = ms_to_ws_bus;
    assign ws_ready_go = 1'b1;

    // Exception/interrupt/ertn decode; ex outranks ertn, interrupts yield to both
    always_comb begin
        take_int     = ws_valid_q & has_int & ~ws_bus_q.ex & ~ws_bus_q.ertn;
        wb_ex        = ws_valid_q & (ws_bus_q.ex | take_int);
        ertn_flush   = ws_valid_q & ws_bus_q.ertn & ~ws_bus_q.ex;
        ws_flush     = wb_ex | ertn_flush;
        flush_target = 32'h0;
        if (wb_ex) begin
            flush_target = ex_entry;
        end else if (ertn_flush) begin
            flush_target = era_pc;
        end
        ws_allow_in  = (~ws_valid_q | ws_ready_go) & ~ws_flush;
    end

    // Next-state: reset wins, a flush retires the held instruction without refilling
    always_comb begin
        ws_valid_d = ws_valid_q;
        ws_bus_d   = ws_bus_q;
        if (reset) begin
            ws_valid_d = 1'b0;
        end else if (ws_flush) begin
            ws_valid_d = 1'b0;
        end else if (ws_allow_in) begin
            ws_valid_d = ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                ws_bus_d = ms_bus;
            end
        end
    end

    // Stage register
    always_ff @(posedge clk) begin
        ws_valid_q <= ws_valid_d;
        ws_bus_q   <= ws_bus_d;
    end

    // CSR, RF, bypass and debug outputs; a faulting instruction writes nothing
    always_comb begin
        csr_ctrl  = {ws_bus_q.csr_num, ws_bus_q.csr_re, ws_bus_q.csr_we,
                     ws_bus_q.csr_wvalue, ws_bus_q.csr_wmask};
        csr_valid = ws_valid_q & ~wb_ex;

        csr_bus.ertn_flush  = ertn_flush;
        csr_bus.wb_ex       = wb_ex;
        csr_bus.wb_ecode    = take_int ? ECODE_INT : ws_bus_q.ecode;
        csr_bus.wb_esubcode = take_int ? ESUBCODE_NONE : ws_bus_q.esubcode;
        csr_bus.wb_pc       = ws_bus_q.pc;
        csr_bus.wb_vaddr    = ws_bus_q.vaddr;
        ws_to_csr_bus       = csr_bus;

        rf_we    = ws_valid_q & ws_bus_q.rf_we & ~wb_ex;
        rf_waddr = ws_bus_q.rf_waddr;
        rf_wdata = ws_bus_q.csr_re ? csr_rvalue : ws_bus_q.rf_wdata;
        ws_fwd   = {rf_we, rf_waddr, rf_wdata};

        debug_wb_pc       = ws_bus_q.pc;
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, compared against a cycle-level behavioural model.
module tb_wb_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [13:0] csr_num;
        logic        csr_re;
        logic        csr_we;
        logic [31:0] csr_wvalue;
        logic [31:0] csr_wmask;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr;
        logic        ertn;
    } inst_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ms_to_ws_valid;
    logic [198:0]  ms_to_ws_bus;
    logic          ws_allow_in;
    logic [79:0]   csr_ctrl;
    logic          csr_valid;
    logic [80:0]   ws_to_csr_bus;
    logic [31:0]   csr_rvalue;
    logic [31:0]   ex_entry;
    logic [31:0]   era_pc;
    logic          has_int;
    logic          ws_flush;
    logic [31:0]   flush_target;
    logic [37:0]   ws_fwd;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [31:0]   debug_wb_pc;
    logic [3:0]    debug_wb_rf_we;
    logic [4:0]    debug_wb_rf_wnum;
    logic [31:0]   debug_wb_rf_wdata;

    inst_t in_inst;
    inst_t m_inst;
    logic  m_valid;
    logic  m_known;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    function automatic logic [198:0] pack(input inst_t i);
        return {i.pc, i.rf_we, i.waddr, i.wdata, i.csr_num, i.csr_re, i.csr_we,
                i.csr_wvalue, i.csr_wmask, i.ex, i.ecode, i.esub, i.vaddr, i.ertn};
    endfunction

    assign ms_to_ws_bus = pack(in_inst);

    wb_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allow_in       (ws_allow_in),
        .csr_ctrl          (csr_ctrl),
        .csr_valid         (csr_valid),
        .ws_to_csr_bus     (ws_to_csr_bus),
        .csr_rvalue        (csr_rvalue),
        .ex_entry          (ex_entry),
        .era_pc            (era_pc),
        .has_int           (has_int),
        .ws_flush          (ws_flush),
        .flush_target      (flush_target),
        .ws_fwd            (ws_fwd),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic inst_t plain(input logic [31:0] pc);
        inst_t i;
        i = '0;
        i.pc = pc;
        return i;
    endfunction

    function automatic inst_t rand_inst();
        inst_t i;
        i.pc         = $urandom;
        i.rf_we      = 1'($urandom_range(0, 1));
        i.waddr      = 5'($urandom);
        i.wdata      = $urandom;
        i.csr_num    = 14'($urandom);
        i.csr_re     = ($urandom_range(0, 3) == 0);
        i.csr_we     = 1'($urandom_range(0, 1));
        i.csr_wvalue = $urandom;
        i.csr_wmask  = $urandom;
        i.ex         = ($urandom_range(0, 7) == 0);
        i.ecode      = 6'($urandom);
        i.esub       = 9'($urandom);
        i.vaddr      = $urandom;
        i.ertn       = ($urandom_range(0, 7) == 0);
        return i;
    endfunction

    // Compare every output against what the architectural rules predict now
    task automatic model_check();
        logic        irq, exc, ret, flush;
        logic [31:0] tgt, wd;
        logic [5:0]  ec;
        logic [8:0]  es;
        logic        we;
        irq   = m_valid && has_int && !m_inst.ex && !m_inst.ertn;
        exc   = m_valid && (m_inst.ex || irq);
        ret   = m_valid && m_inst.ertn && !m_inst.ex;
        flush = exc || ret;
        tgt   = exc ? ex_entry : (ret ? era_pc : 32'h0);
        we    = m_valid && m_inst.rf_we && !exc;
        chk("allow_in", ws_allow_in, !flush);
        chk("ws_flush", ws_flush, flush);
        chk("flush_target", flush_target, tgt);
        chk("csr_valid", csr_valid, m_valid && !exc);
        chk("rf_we", rf_we, we);
        chk("dbg_rf_we", debug_wb_rf_we, {4{we}});
        chk("fwd_we", ws_fwd[37], we);
        chk("wb_flags", ws_to_csr_bus[80:79], {ret, exc});
        if (m_known) begin
            wd = m_inst.csr_re ? csr_rvalue : m_inst.wdata;
            ec = irq ? 6'h0 : m_inst.ecode;
            es = irq ? 9'h0 : m_inst.esub;
            chk("csr_ctrl", csr_ctrl, {m_inst.csr_num, m_inst.csr_re, m_inst.csr_we,
                                       m_inst.csr_wvalue, m_inst.csr_wmask});
            chk("ws_to_csr", ws_to_csr_bus, {ret, exc, ec, es, m_inst.pc, m_inst.vaddr});
            chk("rf_waddr", rf_waddr, m_inst.waddr);
            chk("rf_wdata", rf_wdata, wd);
            chk("ws_fwd", ws_fwd, {we, m_inst.waddr, wd});
            chk("dbg_pc", debug_wb_pc, m_inst.pc);
            chk("dbg_wnum", debug_wb_rf_wnum, m_inst.waddr);
            chk("dbg_wdata", debug_wb_rf_wdata, wd);
        end
    endtask

    // Predict the stage contents after the coming edge
    task automatic model_update();
        logic flush;
        flush = m_valid && (m_inst.ex || m_inst.ertn || has_int);
        if (reset) begin
            m_valid = 1'b0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else begin
            m_valid = ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                m_inst  = in_inst;
                m_known = 1'b1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        inst_t a, b;
        reset          = 1'b1;
        ms_to_ws_valid = 1'b0;
        has_int        = 1'b0;
        csr_rvalue     = 32'h0;
        ex_entry       = 32'h1c00_8000;
        era_pc         = 32'h1c00_0100;
        in_inst        = '0;
        m_valid        = 1'b0;
        m_known        = 1'b0;
        m_inst         = '0;

        // Reset state
        step();
        settle();
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_csr_valid", csr_valid, 1'b0);
        chk("rst_flush", ws_flush, 1'b0);
        advance();
        reset = 1'b0;

        // add r5 = 0x1234, writes for exactly one cycle
        a = plain(32'h1c00_0000);
        a.rf_we = 1'b1; a.waddr = 5'd5; a.wdata = 32'h1234;
        in_inst = a; ms_to_ws_valid = 1'b1;
        step();
        ms_to_ws_valid = 1'b0;
        settle();
        chk("add_we", rf_we, 1'b1);
        chk("add_waddr", rf_waddr, 5'd5);
        chk("add_wdata", rf_wdata, 32'h1234);
        chk("add_noflush", ws_flush, 1'b0);
        advance();
        settle();
        chk("add_one_cycle", rf_we, 1'b0);
        advance();

        // csrrd returns CSR read data
        a = plain(32'h1c00_0004);
        a.rf_we = 1'b1; a.waddr = 5'd4; a.wdata = 32'hdead; a.csr_re = 1'b1;
        in_inst = a; ms_to_ws_valid = 1'b1; csr_rvalue = 32'h8;
        step();
        ms_to_ws_valid = 1'b0;
        settle();
        chk("csrrd_wdata", rf_wdata, 32'h8);
        advance();

        // syscall exception
        a = plain(32'h1c00_0040);
        a.rf_we = 1'b1; a.csr_we = 1'b1; a.ex = 1'b1; a.ecode = 6'h0b;
        in_inst = a; ms_to_ws_valid = 1'b1;
        step();
        ms_to_ws_valid = 1'b0;
        settle();
        chk("sys_flush", ws_flush, 1'b1);
        chk("sys_target", flush_target, 32'h1c00_8000);
        chk("sys_rf_we", rf_we, 1'b0);
        chk("sys_csr_valid", csr_valid, 1'b0);
        chk("sys_wb_pc", ws_to_csr_bus[63:32], 32'h1c00_0040);
        chk("sys_ecode", ws_to_csr_bus[78:73], 6'h0b);
        advance();

        // ertn
        a = plain(32'h1c00_0080);
        a.ertn = 1'b1;
        in_inst = a; ms_to_ws_valid = 1'b1;
        step();
        ms_to_ws_valid = 1'b0;
        settle();
        chk("ertn_flag", ws_to_csr_bus[80], 1'b1);
        chk("ertn_target", flush_target, 32'h1c00_0100);
        chk("ertn_wb_ex", ws_to_csr_bus[79], 1'b0);
        advance();

        // Interrupt over a normal instruction; next instruction must bounce
        a = plain(32'h1c00_00c0);
        a.rf_we = 1'b1; a.waddr = 5'd7; a.ecode = 6'h15;
        b = plain(32'h1c00_00c4);
        b.rf_we = 1'b1;
        in_inst = a; ms_to_ws_valid = 1'b1;
        step();
        in_inst = b; has_int = 1'b1;
        settle();
        chk("int_wb_ex", ws_to_csr_bus[79], 1'b1);
        chk("int_ecode", ws_to_csr_bus[78:73], 6'h0);
        chk("int_rf_we", rf_we, 1'b0);
        chk("int_allow_in", ws_allow_in, 1'b0);
        advance();
        has_int = 1'b0; ms_to_ws_valid = 1'b0;
        settle();
        chk("int_not_taken_we", rf_we, 1'b0);
        chk("int_not_taken_pc", debug_wb_pc, 32'h1c00_00c0);
        advance();

        // Reset while an excepting instruction sits in WB
        a = plain(32'h1c00_0100);
        a.ex = 1'b1; a.rf_we = 1'b1;
        in_inst = a; ms_to_ws_valid = 1'b1;
        step();
        in_inst = b; reset = 1'b1;
        step();
        reset = 1'b0; ms_to_ws_valid = 1'b0;
        settle();
        chk("rstex_rf_we", rf_we, 1'b0);
        chk("rstex_csr_valid", csr_valid, 1'b0);
        chk("rstex_flags", ws_to_csr_bus[80:79], 2'b00);
        chk("rstex_flush", ws_flush, 1'b0);
        chk("rstex_fwd_we", ws_fwd[37], 1'b0);
        advance();

        // Reset beats a concurrent load into an empty stage
        in_inst = b; ms_to_ws_valid = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; ms_to_ws_valid = 1'b0;
        settle();
        chk("rst_vs_load", rf_we, 1'b0);
        advance();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            in_inst        = rand_inst();
            ms_to_ws_valid = 1'($urandom_range(0, 1));
            has_int        = ($urandom_range(0, 7) == 0);
            reset          = ($urandom_range(0, 31) == 0);
            csr_rvalue     = $urandom;
            ex_entry       = $urandom;
            era_pc         = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
